// File: rtl/mpu341_isa_pkg.sv
// rtl/mpu341_isa_pkg.sv - MPU341 ISA codes: op types, register codes, opcode prefixes
package mpu341_isa_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_ALU  = 3'd2;
    localparam logic [2:0] OP_JMP  = 3'd3;
    localparam logic [2:0] OP_JNZ  = 3'd4;
    localparam logic [2:0] OP_IN   = 3'd5;

    localparam logic [2:0] REG_X0   = 3'd0;
    localparam logic [2:0] REG_X1   = 3'd1;
    localparam logic [2:0] REG_Y0   = 3'd2;
    localparam logic [2:0] REG_Y1   = 3'd3;
    localparam logic [2:0] REG_OREG = 3'd4;
    localparam logic [2:0] REG_M    = 3'd5;
    localparam logic [2:0] REG_I    = 3'd6;
    localparam logic [2:0] REG_DM   = 3'd7;
    // In the source field code 4 names r, not o_reg.
    localparam logic [2:0] SRC_R    = 3'd4;

    localparam logic       PFX_LOAD = 1'b0;
    localparam logic [1:0] PFX_MOV  = 2'b10;
    localparam logic [2:0] PFX_ALU  = 3'b110;
    localparam logic [3:0] PFX_JMP  = 4'b1110;
    localparam logic [3:0] PFX_JNZ  = 4'b1111;

    // src==dst would collide with the IN encoding, except for code 4 where
    // source r and destination o_reg are different registers.
    function automatic logic mov_is_self(input logic [2:0] dst, input logic [2:0] src);
        return (src == dst) && (src != SRC_R);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - op handshake and program-memory write bus of instr_encoder
interface instr_encoder_if;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_type;
    logic [2:0] op_dst;
    logic [2:0] op_src;
    logic [3:0] op_imm;
    logic [2:0] op_func;
    logic       pm_we;
    logic [7:0] pm_addr;
    logic [7:0] pm_wdata;

    modport master (
        output op_valid, op_type, op_dst, op_src, op_imm, op_func,
        input  op_ready, pm_we, pm_addr, pm_wdata
    );

    modport slave (
        input  op_valid, op_type, op_dst, op_src, op_imm, op_func,
        output op_ready, pm_we, pm_addr, pm_wdata
    );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational op-to-instruction-word packer with legality check
module instr_pack
    import mpu341_isa_pkg::*;
(
    input  logic [2:0] op_type,
    input  logic [2:0] op_dst,
    input  logic [2:0] op_src,
    input  logic [3:0] op_imm,
    input  logic [2:0] op_func,
    output logic [7:0] word,
    output logic       legal
);

    always_comb begin
        word  = 8'h00;
        legal = 1'b1;
        case (op_type)
            OP_LOAD: word = {PFX_LOAD, op_dst, op_imm};
            OP_MOV: begin
                word  = {PFX_MOV, op_dst, op_src};
                legal = !mov_is_self(op_dst, op_src);
            end
            OP_IN:   word = {PFX_MOV, op_dst, op_dst};
            OP_ALU:  word = {PFX_ALU, op_imm[1:0], op_func};
            OP_JMP:  word = {PFX_JMP, op_imm};
            OP_JNZ:  word = {PFX_JNZ, op_imm};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - load-session FSM writing encoded ops to program memory
module instr_encoder
    import mpu341_isa_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            base_addr,
    instr_encoder_if.slave        bus,
    output logic                  busy,
    output logic                  full,
    output logic                  err,
    output logic [8:0]            word_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [8:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       we_q, we_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pdata_q, pdata_d;

    logic [7:0] word;
    logic       legal;
    logic       ready;
    logic       accept;

    instr_pack u_pack (
        .op_type (bus.op_type),
        .op_dst  (bus.op_dst),
        .op_src  (bus.op_src),
        .op_imm  (bus.op_imm),
        .op_func (bus.op_func),
        .word    (word),
        .legal   (legal)
    );

    // A start cycle never accepts, so restart and accept are mutually exclusive.
    assign ready  = (state_q == S_ACTIVE) && !start;
    assign accept = bus.op_valid && ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = 1'b0;
        paddr_d = paddr_q;
        pdata_d = pdata_q;
        if (start) begin
            state_d = S_ACTIVE;
            addr_d  = base_addr;
            cnt_d   = 9'd0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                paddr_d = addr_q;
                pdata_d = word;
                cnt_d   = cnt_q + 9'd1;
                if (addr_q == 8'hFF) begin
                    state_d = S_FULL;
                end else begin
                    addr_d = addr_q + 8'd1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= 8'h00;
            cnt_q   <= 9'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            paddr_q <= 8'h00;
            pdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            paddr_q <= paddr_d;
            pdata_q <= pdata_d;
        end
    end

    assign bus.op_ready = ready;
    assign bus.pm_we    = we_q;
    assign bus.pm_addr  = paddr_q;
    assign bus.pm_wdata = pdata_q;
    assign busy         = (state_q != S_IDLE);
    assign full         = (state_q == S_FULL);
    assign err          = err_q;
    assign word_count   = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] base_addr;
    logic       busy, full, err;
    logic [8:0] word_count;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .full       (full),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit m_open, m_full, m_err, m_we;
    int m_addr, m_cnt, m_paddr, m_pdata;

    typedef struct {
        logic       st;
        logic [7:0] base;
        logic [2:0] t, d, s;
        logic [3:0] imm;
        logic [2:0] f;
        logic       exp_we;
        logic [7:0] exp_addr, exp_data;
        logic       exp_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Instruction word from the ISA table; -1 marks a rejected op.
    function automatic int ref_word(int t, int d, int s, int imm, int f);
        case (t)
            0: return d * 16 + imm;
            1: return (s == d && s != 4) ? -1 : 128 + d * 8 + s;
            5: return 128 + d * 9;
            2: return 192 + (imm % 4) * 8 + f;
            3: return 224 + imm;
            4: return 240 + imm;
            default: return -1;
        endcase
    endfunction

    task automatic check_outputs();
        chk("pm_we", bus.pm_we, m_we);
        chk("pm_addr", bus.pm_addr, m_paddr);
        chk("pm_wdata", bus.pm_wdata, m_pdata);
        chk("busy", busy, m_open);
        chk("full", full, m_full);
        chk("err", err, m_err);
        chk("word_count", word_count, m_cnt);
    endtask

    task automatic model_clear();
        m_open = 0; m_full = 0; m_err = 0; m_we = 0;
        m_addr = 0; m_cnt = 0; m_paddr = 0; m_pdata = 0;
    endtask

    // One clock: drive at posedge+1, check op_ready, update model, check outputs at next posedge+1.
    task automatic cycle(input logic st, input logic [7:0] base, input logic v,
                         input logic [2:0] t, input logic [2:0] d, input logic [2:0] s,
                         input logic [3:0] imm, input logic [2:0] f);
        bit rdy;
        int w;
        start = st; base_addr = base;
        bus.op_valid = v; bus.op_type = t; bus.op_dst = d;
        bus.op_src = s; bus.op_imm = imm; bus.op_func = f;
        #1;
        rdy = m_open && !m_full && !st;
        chk("op_ready", bus.op_ready, rdy);
        m_we = 0;
        if (st) begin
            m_open = 1; m_full = 0; m_err = 0; m_addr = base; m_cnt = 0;
        end else if (v && rdy) begin
            w = ref_word(t, d, s, imm, f);
            if (w < 0) m_err = 1;
            else begin
                m_we = 1; m_paddr = m_addr; m_pdata = w; m_cnt++;
                if (m_addr == 255) m_full = 1;
                else m_addr++;
            end
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(0, 8'h00, 0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pm_we"}, bus.pm_we, 0);
        chk({tag, "_pm_addr"}, bus.pm_addr, 0);
        chk({tag, "_pm_wdata"}, bus.pm_wdata, 0);
        chk({tag, "_op_ready"}, bus.op_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h10, 3'd0, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 3'd0, 3'd5, 3'd0, 4'hA, 3'd0, 1'b1, 8'h10, 8'h5A, 1'b0};
        tbl[2]  = '{1'b1, 8'h10, 3'd0, 3'd0, 3'd0, 4'h0, 3'd0, 1'b0, 8'h10, 8'h5A, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 3'd1, 3'd4, 3'd4, 4'h0, 3'd0, 1'b1, 8'h10, 8'hA4, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 3'd5, 3'd1, 3'd6, 4'h0, 3'd0, 1'b1, 8'h11, 8'h89, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 3'd2, 3'd0, 3'd0, 4'h2, 3'd3, 1'b1, 8'h12, 8'hD3, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 3'd4, 3'd0, 3'd0, 4'h7, 3'd0, 1'b1, 8'h13, 8'hF7, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 3'd1, 3'd2, 3'd2, 4'h0, 3'd0, 1'b0, 8'h13, 8'hF7, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 3'd6, 3'd1, 3'd0, 4'h1, 3'd0, 1'b0, 8'h13, 8'hF7, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 3'd3, 3'd0, 3'd0, 4'h3, 3'd0, 1'b1, 8'h14, 8'hE3, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 3'd1, 3'd0, 3'd4, 4'h0, 3'd0, 1'b1, 8'h15, 8'h84, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 3'd0, 3'd7, 3'd0, 4'hF, 3'd0, 1'b1, 8'h16, 8'h7F, 1'b1};

        reset_n = 1'b0; start = 1'b0; base_addr = 8'h00;
        bus.op_valid = 1'b0; bus.op_type = 3'd0; bus.op_dst = 3'd0;
        bus.op_src = 3'd0; bus.op_imm = 4'd0; bus.op_func = 3'd0;
        model_clear();
        #3;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].base, !tbl[i].st, tbl[i].t, tbl[i].d,
                  tbl[i].s, tbl[i].imm, tbl[i].f);
            chk($sformatf("tbl%0d_we", i), bus.pm_we, tbl[i].exp_we);
            chk($sformatf("tbl%0d_addr", i), bus.pm_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_data", i), bus.pm_wdata, tbl[i].exp_data);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
        end
        idle();

        // Address space exhaustion and resume from a new base.
        cycle(1, 8'hFE, 0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
        cycle(0, 8'h00, 1, 3'd0, 3'd0, 3'd0, 4'd1, 3'd0);
        chk("full_w1_addr", bus.pm_addr, 8'hFE);
        cycle(0, 8'h00, 1, 3'd0, 3'd0, 3'd0, 4'd2, 3'd0);
        chk("full_w2_addr", bus.pm_addr, 8'hFF);
        chk("full_set", full, 1);
        chk("full_ready_low", bus.op_ready, 0);
        cycle(0, 8'h00, 1, 3'd0, 3'd0, 3'd0, 4'd3, 3'd0);
        cycle(0, 8'h00, 1, 3'd0, 3'd0, 3'd0, 4'd3, 3'd0);
        chk("full_stall_we", bus.pm_we, 0);
        cycle(1, 8'h00, 1, 3'd0, 3'd0, 3'd0, 4'd3, 3'd0);
        chk("full_restart_no_we", bus.pm_we, 0);
        cycle(0, 8'h00, 1, 3'd0, 3'd0, 3'd0, 4'd3, 3'd0);
        chk("full_resume_we", bus.pm_we, 1);
        chk("full_resume_addr", bus.pm_addr, 8'h00);
        chk("full_resume_data", bus.pm_wdata, 8'h03);
        chk("full_resume_full", full, 0);

        // Back-to-back writes, then restart with a write in flight.
        cycle(1, 8'h40, 0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h00, 1, 3'd3, 3'd0, 3'd0, 4'(i), 3'd0);
            chk($sformatf("b2b%0d_we", i), bus.pm_we, 1);
            chk($sformatf("b2b%0d_addr", i), bus.pm_addr, 8'h40 + 8'(i));
        end
        cycle(0, 8'h00, 1, 3'd3, 3'd0, 3'd0, 4'd9, 3'd0);
        chk("restart_pending_we", bus.pm_we, 1);
        chk("restart_pending_addr", bus.pm_addr, 8'h44);
        cycle(1, 8'h80, 1, 3'd3, 3'd0, 3'd0, 4'd10, 3'd0);
        cycle(0, 8'h00, 1, 3'd3, 3'd0, 3'd0, 4'd10, 3'd0);
        chk("restart_addr", bus.pm_addr, 8'h80);
        chk("restart_data", bus.pm_wdata, 8'hEA);
        chk("restart_wc", word_count, 1);

        // Reset right after an accept cancels the pending write.
        start = 0; bus.op_valid = 1; bus.op_type = 3'd0; bus.op_dst = 3'd1; bus.op_imm = 4'h6;
        #1;
        chk("rst_accept_ready", bus.op_ready, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_clear();
        @(posedge clk); #1;
        check_all_zero("rst_held");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 3'd0, 3'd1, 3'd0, 4'h6, 3'd0);
        chk("rst_no_we", bus.pm_we, 0);

        // Randomized sessions against the reference model.
        for (int i = 0; i < 800; i++) begin
            logic st;
            logic [7:0] b;
            st = (i == 0) || ($urandom_range(0, 24) == 0);
            b = ($urandom_range(0, 3) == 0) ? 8'hF8 + 8'($urandom_range(0, 7)) : 8'($urandom);
            cycle(st, b, ($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom),
                  3'($urandom), 4'($urandom), 3'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse; opens a load session at base_addr.
REQ-004 base_addr  input  8  first program-memory address of the session, sampled on start.
REQ-005 op_valid  input  1  operation present on op_* fields.
REQ-006 op_ready  output  1  encoder accepts the operation this cycle (transfer = op_valid & op_ready).
REQ-007 op_type  input  3  0 LOAD, 1 MOV, 2 ALU, 3 JMP, 4 JNZ, 5 IN; 6-7 illegal.
REQ-008 op_dst  input  3  destination register code: x0=0, x1=1, y0=2, y1=3, o_reg=4, m=5, i=6, dm=7.
REQ-009 op_src  input  3  source register code (MOV only; 4 = r).
REQ-010 op_imm  input  4  LOAD data, JMP/JNZ target nibble, or {x_sel,y_sel} in bits 1:0 for ALU.
REQ-011 op_func  input  3  ALU function select.
REQ-012 pm_we, pm_addr, pm_wdata  output  1/8/8  program-memory write strobe, address and instruction word.
REQ-013 busy, full, err  output  1/1/1  session open; address space exhausted; sticky illegal-op flag.
REQ-014 word_count  output  9  words written in the current session.

Function
REQ-015 The block SHALL encode each op as follows:
- LOAD: {0,dst,imm}
- MOV: {10,dst,src}
- IN: {10,dst,dst}
- ALU: {110,imm[1:0],func}
- JMP: {1110,imm}
- JNZ: {1111,imm}
REQ-016 The block SHALL reject (no write; err set) illegal op_type, and MOV with op_src==op_dst (an input read is issued only via IN).
REQ-017 The block SHALL implement FSM IDLE -> ACTIVE on start; ACTIVE -> FULL after the write to address 8'hFF; FULL -> ACTIVE on start; any state -> IDLE on stop condition none (session persists until the next start or reset).
REQ-018 op_ready SHALL be 1 only in ACTIVE, and combinationally independent of op_valid.
REQ-019 An accepted op SHALL produce pm_we=1 exactly one cycle later, with the registered pm_addr and pm_wdata (latency 1); a rejected op SHALL produce no strobe.
REQ-020 After each write, the address SHALL increment by 1; word_count SHALL increment by 1 for each write.
REQ-021 Writing 8'hFF SHALL assert full the following cycle and drop op_ready in that same cycle; the address SHALL NOT wrap.
REQ-022 A start pulse in ACTIVE or FULL SHALL take effect as follows:
- any pending registered write still issues;
- the next cycle loads base_addr, clears word_count, full and err;
- ops presented in the start cycle are not accepted.
REQ-023 start and op_valid in the same cycle while IDLE SHALL accept no op.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 pm_wdata and pm_addr SHALL hold their last value when pm_we=0.

Reset
REQ-026 On reset_n=0, the block SHALL immediately set:
- state = IDLE;
- pm_we = 0, pm_addr = 0, pm_wdata = 0;
- op_ready = 0, busy = 0, full = 0, err = 0;
- word_count = 0.
REQ-027 Reset asserted mid-session SHALL cancel any pending write; no pm_we SHALL occur after reset is released until a new start pulse.

Structure
REQ-028 Register codes, op_type codes and opcode prefixes SHALL live in the shared package mpu341_isa_pkg.
REQ-029 Encoding and legality checks SHALL reside in one combinational sub-module instr_pack (inputs op_*; outputs word[7:0] and legal).
REQ-030 The FSM, address counter, word_count and output register SHALL reside in instr_encoder.

Verification
REQ-031 Single ops: start with base=8'h10, then LOAD dst=m imm=4'hA -> pm_we at 8'h10 with data 8'h5A, one cycle after acceptance.
REQ-032 Mix of ops:
- MOV dst=o_reg src=r -> 8'hA4;
- IN dst=x1 -> 8'h89;
- ALU imm=2'b10 func=3 -> 8'hD3;
- JNZ imm=7 -> 8'hF7;
- addresses 8'h10..13 consecutive.
REQ-033 Illegal ops: MOV src=dst=y0, then op_type=6 -> no pm_we, err=1, address unchanged; the following legal op is written at the unchanged address.
REQ-034 Full: start base=8'hFE, stream 3 ops with op_valid held -> writes at FE and FF, full=1, op_ready=0, third op stalls; start with base=0 resumes and writes the third op at 8'h00.
REQ-035 Back-to-back and restart: op_valid held for 4 cycles -> 4 writes in consecutive cycles; start mid-stream -> the pending write completes, and the next write lands at the new base with word_count=1.
REQ-036 Reset: assert reset_n=0 the cycle after an accept -> no pm_we; all outputs are 0 while reset_n=0.
